// File: rtl/snn_delay_layer.sv
// -----------------------------------------------------------------------------
// snn_delay_layer
//
// One fully connected layer of leaky integrate-and-fire neurons with
// programmable per-synapse axonal delays. Each input channel keeps a short
// shift history of its past spikes. On every processed timestep ("tick"), each
// synapse taps that history at its own delay. The enabled, firing synapses are
// summed into the neuron's potential. The sum is leaked by 'decay', saturated
// to 0..255 and compared against 'threshold'. After firing, the neuron is held
// at zero for 'refractory_period' ticks.
//
// Ports
//   clk                     sole clock, rising edge
//   reset                   synchronous, active-high; clears all state
//   enable                  global gate; low freezes all state, ignores step
//   step                    timestep strobe; enable & step = tick
//   input_spikes [M]        spikes for the current timestep
//   weights [N*M*8]         signed weight of synapse (n,m) at [(n*M+m)*8 +: 8]
//   delay_values [N*M*DW]   delay of synapse (n,m) at [(n*M+m)*DW +: DW]
//   synapse_en [N*M]        per-synapse enable at bit n*M+m
//   threshold [8]           unsigned firing threshold, shared by all neurons
//   decay [8]               unsigned leak per tick, shared by all neurons
//   refractory_period [8]   ticks a neuron is held after firing
//   membrane_potential_out  registered potential of neuron n at [n*8 +: 8]
//   output_spikes [N]       one-cycle spike pulses, visible the cycle after a tick
//   spike_valid             one-cycle pulse marking a processed tick
// -----------------------------------------------------------------------------
module snn_delay_layer #(
   parameter int M  = 24,
   parameter int N  = 8,
   parameter int DW = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                step,
   input  logic [M-1:0]        input_spikes,
   input  logic [N*M*8-1:0]    weights,
   input  logic [N*M*DW-1:0]   delay_values,
   input  logic [N*M-1:0]      synapse_en,
   input  logic [7:0]          threshold,
   input  logic [7:0]          decay,
   input  logic [7:0]          refractory_period,
   output logic [N*8-1:0]      membrane_potential_out,
   output logic [N-1:0]        output_spikes,
   output logic                spike_valid
);

   localparam int D  = 2 ** DW;          // history depth, delays 0..D-1
   localparam int HW = D - 1;            // stored history bits per channel
   localparam int SW = 8 + $clog2(M) + 1; // exact width of a synaptic sum
   localparam int VW = SW + 2;           // room for P + S - decay without wrap

   logic              tick;

   logic [HW-1:0]     hist_q [M];
   logic [HW-1:0]     hist_d [M];
   logic [D-1:0]      tap    [M];

   logic [SW-1:0]     syn_sum [N];
   logic [VW-1:0]     v_full  [N];
   logic [7:0]        v_sat   [N];

   logic [7:0]        pot_q [N];
   logic [7:0]        pot_d [N];
   logic [7:0]        ref_q [N];
   logic [7:0]        ref_d [N];
   logic [N-1:0]      fire;

   assign tick = enable & step;

   // tap[m][k] is the spike channel m carried k ticks ago. Bit 0 is the live
   // input, so a delay value indexes it directly. The shifted history is the
   // low HW bits, which also covers the single-bit D=2 case.
   always_comb begin
      for (int m = 0; m < M; m++) begin
         tap[m]    = {hist_q[m], input_spikes[m]};
         hist_d[m] = tap[m][HW-1:0];
      end
   end

   // Synaptic sums, sign-extended to SW bits so no combination of M weights
   // can overflow.
   always_comb begin
      for (int n = 0; n < N; n++) begin
         syn_sum[n] = '0;
         for (int m = 0; m < M; m++) begin
            if (synapse_en[n*M+m] && tap[m][delay_values[(n*M+m)*DW +: DW]]) begin
               syn_sum[n] = syn_sum[n]
                          + {{(SW-8){weights[(n*M+m)*8+7]}}, weights[(n*M+m)*8 +: 8]};
            end
         end
      end
   end

   // Leak, saturate and fire. V is evaluated in two's complement at VW bits;
   // the MSB is its sign and any set bit above bit 7 means V exceeds 255.
   // NOTE: every combinational output gets a default before any branch, so no
   // path can leave a value unassigned and infer a latch.
   always_comb begin
      for (int n = 0; n < N; n++) begin
         v_full[n] = {{(VW-8){1'b0}}, pot_q[n]}
                   + {{(VW-SW){syn_sum[n][SW-1]}}, syn_sum[n]}
                   - {{(VW-8){1'b0}}, decay};

         if (v_full[n][VW-1])
            v_sat[n] = 8'd0;
         else if (|v_full[n][VW-2:8])
            v_sat[n] = 8'd255;
         else
            v_sat[n] = v_full[n][7:0];

         pot_d[n] = pot_q[n];
         ref_d[n] = ref_q[n];
         fire[n]  = 1'b0;

         if (ref_q[n] != 8'd0) begin
            ref_d[n] = ref_q[n] - 8'd1;
            pot_d[n] = 8'd0;
         end else if (v_sat[n] >= threshold) begin
            fire[n]  = 1'b1;
            pot_d[n] = 8'd0;
            ref_d[n] = refractory_period;
         end else begin
            pot_d[n] = v_sat[n];
         end
      end
   end

   // NOTE: the spike history is cleared on reset like the rest of the state,
   // so no delayed spike queued before reset can surface after it.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int m = 0; m < M; m++) hist_q[m] <= '0;
         for (int n = 0; n < N; n++) begin
            pot_q[n] <= 8'd0;
            ref_q[n] <= 8'd0;
         end
         output_spikes <= '0;
         spike_valid   <= 1'b0;
      end else begin
         // Outputs are pulses: any non-tick cycle clears them.
         output_spikes <= tick ? fire : '0;
         spike_valid   <= tick;
         if (tick) begin
            hist_q <= hist_d;
            pot_q  <= pot_d;
            ref_q  <= ref_d;
         end
      end
   end

   for (genvar n = 0; n < N; n++) begin : g_pot_out
      assign membrane_potential_out[n*8 +: 8] = pot_q[n];
   end

endmodule

// File: tb/tb_snn_delay_layer.sv
// -----------------------------------------------------------------------------
// tb_snn_delay_layer
//
// Directed scenarios for integration, delays, saturation, refractory hold,
// enable gating and reset, followed by a randomized run. Expected values come
// from constants or from a timestep-level model that keeps a queue of past
// input vectors and applies the neuron rules with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_snn_delay_layer;

   localparam int M  = 24;
   localparam int N  = 8;
   localparam int DW = 3;
   localparam int D  = 2 ** DW;

   logic                clk = 1'b0;
   logic                reset;
   logic                enable;
   logic                step;
   logic [M-1:0]        input_spikes;
   logic [N*M*8-1:0]    weights;
   logic [N*M*DW-1:0]   delay_values;
   logic [N*M-1:0]      synapse_en;
   logic [7:0]          threshold;
   logic [7:0]          decay;
   logic [7:0]          refractory_period;
   logic [N*8-1:0]      membrane_potential_out;
   logic [N-1:0]        output_spikes;
   logic                spike_valid;

   snn_delay_layer #(.M(M), .N(N), .DW(DW)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .enable                 (enable),
      .step                   (step),
      .input_spikes           (input_spikes),
      .weights                (weights),
      .delay_values           (delay_values),
      .synapse_en             (synapse_en),
      .threshold              (threshold),
      .decay                  (decay),
      .refractory_period      (refractory_period),
      .membrane_potential_out (membrane_potential_out),
      .output_spikes          (output_spikes),
      .spike_valid            (spike_valid)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int           mp [N];
   int           mr [N];
   logic [M-1:0] past [$];     // past[k] = input vector of k+1 ticks ago
   logic [N-1:0] e_spk;
   logic         e_valid;

   function automatic void clear_cfg();
      weights           = '0;
      delay_values      = '0;
      synapse_en        = '0;
      threshold         = 8'd0;
      decay             = 8'd0;
      refractory_period = 8'd0;
   endfunction

   function automatic void set_syn(input int n, input int m, input int w, input int d);
      weights[(n*M+m)*8 +: 8]       = 8'(w);
      delay_values[(n*M+m)*DW +: DW] = DW'(d);
      synapse_en[n*M+m]             = 1'b1;
   endfunction

   function automatic void model_reset();
      for (int n = 0; n < N; n++) begin
         mp[n] = 0;
         mr[n] = 0;
      end
      past.delete();
      e_spk   = '0;
      e_valid = 1'b0;
   endfunction

   function automatic void model_tick(input logic [M-1:0] sp);
      for (int n = 0; n < N; n++) begin
         int sum = 0;
         for (int m = 0; m < M; m++) begin
            if (synapse_en[n*M+m]) begin
               int   d = int'(delay_values[(n*M+m)*DW +: DW]);
               logic a;
               if (d == 0)                a = sp[m];
               else if (d - 1 < past.size()) a = past[d-1][m];
               else                       a = 1'b0;
               if (a) sum += int'($signed(weights[(n*M+m)*8 +: 8]));
            end
         end
         e_spk[n] = 1'b0;
         if (mr[n] > 0) begin
            mr[n] -= 1;
            mp[n] = 0;
         end else begin
            int v = mp[n] + sum - int'(decay);
            if (v < 0)   v = 0;
            if (v > 255) v = 255;
            if (v >= int'(threshold)) begin
               e_spk[n] = 1'b1;
               mp[n] = 0;
               mr[n] = int'(refractory_period);
            end else begin
               mp[n] = v;
            end
         end
      end
      e_valid = 1'b1;
      past.push_front(sp);
      if (past.size() > D - 1) void'(past.pop_back());
   endfunction

   // Drive one cycle, advance the model, and return 1 ns after the edge.
   task automatic cycle(input logic en, input logic st, input logic [M-1:0] sp);
      reset        = 1'b0;
      enable       = en;
      step         = st;
      input_spikes = sp;
      if (en && st) model_tick(sp);
      else begin
         e_spk   = '0;
         e_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   // Reset overrides an active tick with all inputs spiking.
   task automatic do_reset();
      reset        = 1'b1;
      enable       = 1'b1;
      step         = 1'b1;
      input_spikes = '1;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      enable = 1'b0;
      step   = 1'b0;
      model_reset();
   endtask

   function automatic int pot(input int n);
      return int'(membrane_potential_out[n*8 +: 8]);
   endfunction

   function automatic logic [M-1:0] onehot(input int m);
      logic [M-1:0] v = '0;
      v[m] = 1'b1;
      return v;
   endfunction

   task automatic test_reset();
      clear_cfg();
      for (int n = 0; n < N; n++) set_syn(n, n, 127, 0);
      do_reset();
      checks++;
      if (membrane_potential_out !== '0) begin
         failures++;
         $display("FAIL reset_pot: got %h expected 0", membrane_potential_out);
      end
      checks++;
      if (output_spikes !== '0) begin
         failures++;
         $display("FAIL reset_spikes: got %b expected 0", output_spikes);
      end
      checks++;
      if (spike_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid: got %b expected 0", spike_valid);
      end
   endtask

   task automatic test_integrate();
      int exp_p [3] = '{10, 20, 0};
      clear_cfg();
      do_reset();
      set_syn(0, 0, 10, 0);
      threshold = 8'd30;
      for (int t = 0; t < 3; t++) begin
         cycle(1'b1, 1'b1, onehot(0));
         checks++;
         if (pot(0) !== exp_p[t]) begin
            failures++;
            $display("FAIL integrate_pot t%0d: got %0d expected %0d", t, pot(0), exp_p[t]);
         end
         checks++;
         if (output_spikes[0] !== (t == 2) || spike_valid !== 1'b1) begin
            failures++;
            $display("FAIL integrate_spike t%0d: got spk=%b valid=%b expected spk=%b valid=1",
                     t, output_spikes[0], spike_valid, (t == 2));
         end
      end
      cycle(1'b0, 1'b0, '0);
      checks++;
      if (output_spikes !== '0 || spike_valid !== 1'b0) begin
         failures++;
         $display("FAIL pulse_clear: got spk=%b valid=%b expected 0/0", output_spikes, spike_valid);
      end
   endtask

   task automatic test_delay();
      clear_cfg();
      do_reset();
      set_syn(1, 5, 50, 5);
      threshold = 8'd40;
      for (int t = 0; t < 7; t++) begin
         logic [N-1:0] exp_s;
         exp_s = (t == 5) ? N'(2) : N'(0);
         cycle(1'b1, 1'b1, (t == 0) ? onehot(5) : '0);
         checks++;
         if (output_spikes !== exp_s) begin
            failures++;
            $display("FAIL delay_spike t%0d: got %b expected %b", t, output_spikes, exp_s);
         end
      end
   endtask

   task automatic test_saturation();
      clear_cfg();
      do_reset();
      threshold = 8'd255;
      set_syn(0, 0, 20, 0);
      cycle(1'b1, 1'b1, onehot(0));
      checks++;
      if (pot(0) !== 20) begin
         failures++;
         $display("FAIL sat_setup: got %0d expected 20", pot(0));
      end
      set_syn(0, 1, -100, 0);
      decay = 8'd3;
      cycle(1'b1, 1'b1, onehot(1));
      checks++;
      if (pot(0) !== 0 || output_spikes[0] !== 1'b0) begin
         failures++;
         $display("FAIL sat_low: got pot=%0d spk=%b expected pot=0 spk=0", pot(0), output_spikes[0]);
      end
      decay = 8'd0;
      set_syn(0, 2, 100, 0);
      cycle(1'b1, 1'b1, onehot(2));
      cycle(1'b1, 1'b1, onehot(2));
      checks++;
      if (pot(0) !== 200) begin
         failures++;
         $display("FAIL sat_200: got %0d expected 200", pot(0));
      end
      set_syn(0, 3, 127, 0);
      set_syn(0, 4, 127, 0);
      set_syn(0, 5, 127, 0);
      cycle(1'b1, 1'b1, onehot(3) | onehot(4) | onehot(5));
      checks++;
      if (output_spikes[0] !== 1'b1 || pot(0) !== 0) begin
         failures++;
         $display("FAIL sat_high: got spk=%b pot=%0d expected spk=1 pot=0", output_spikes[0], pot(0));
      end
   endtask

   task automatic test_refractory();
      logic exp_s [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      clear_cfg();
      do_reset();
      set_syn(0, 0, 100, 0);
      threshold         = 8'd50;
      refractory_period = 8'd2;
      for (int t = 0; t < 4; t++) begin
         cycle(1'b1, 1'b1, onehot(0));
         checks++;
         if (output_spikes[0] !== exp_s[t] || pot(0) !== 0) begin
            failures++;
            $display("FAIL refractory t%0d: got spk=%b pot=%0d expected spk=%b pot=0",
                     t, output_spikes[0], pot(0), exp_s[t]);
         end
      end
   endtask

   task automatic test_enable();
      clear_cfg();
      do_reset();
      threshold = 8'd100;
      set_syn(0, 0, 10, 0);
      set_syn(0, 1, 10, 2);
      cycle(1'b1, 1'b1, onehot(0) | onehot(1));
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b1, '1);
         checks++;
         if (pot(0) !== 10 || output_spikes !== '0 || spike_valid !== 1'b0) begin
            failures++;
            $display("FAIL enable_hold k%0d: got pot=%0d spk=%b valid=%b expected 10/0/0",
                     k, pot(0), output_spikes, spike_valid);
         end
      end
      cycle(1'b1, 1'b1, '0);
      checks++;
      if (pot(0) !== 10 || spike_valid !== 1'b1) begin
         failures++;
         $display("FAIL enable_resume1: got pot=%0d valid=%b expected 10/1", pot(0), spike_valid);
      end
      cycle(1'b1, 1'b1, '0);
      checks++;
      if (pot(0) !== 20) begin
         failures++;
         $display("FAIL enable_resume2: got %0d expected 20", pot(0));
      end
   endtask

   task automatic test_reset_pending();
      clear_cfg();
      do_reset();
      set_syn(0, 0, 100, 3);
      threshold = 8'd50;
      cycle(1'b1, 1'b1, onehot(0));
      cycle(1'b1, 1'b1, '0);
      do_reset();
      checks++;
      if (membrane_potential_out !== '0 || output_spikes !== '0 || spike_valid !== 1'b0) begin
         failures++;
         $display("FAIL pend_reset: got pot=%h spk=%b valid=%b expected all 0",
                  membrane_potential_out, output_spikes, spike_valid);
      end
      for (int t = 0; t < 4; t++) begin
         cycle(1'b1, 1'b1, '0);
         checks++;
         if (output_spikes !== '0 || pot(0) !== 0) begin
            failures++;
            $display("FAIL pend_ghost t%0d: got spk=%b pot=%0d expected 0/0", t, output_spikes, pot(0));
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if (c % 50 == 0) begin
            for (int i = 0; i < N*M; i++) begin
               weights[i*8 +: 8]       = 8'($urandom);
               delay_values[i*DW +: DW] = DW'($urandom);
               synapse_en[i]           = 1'($urandom);
            end
            threshold         = (c == 100) ? 8'd0 : 8'($urandom_range(20, 220));
            decay             = 8'($urandom_range(0, 15));
            refractory_period = 8'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 99) < 3) do_reset();
         else begin
            logic [M-1:0] sp;
            for (int m = 0; m < M; m++) sp[m] = ($urandom_range(0, 3) == 0);
            cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), sp);
         end
         begin
            logic [N*8-1:0] exp_mem;
            for (int n = 0; n < N; n++) exp_mem[n*8 +: 8] = 8'(mp[n]);
            checks++;
            if (membrane_potential_out !== exp_mem) begin
               failures++;
               $display("FAIL rand_pot c%0d: got %h expected %h", c, membrane_potential_out, exp_mem);
            end
            checks++;
            if (output_spikes !== e_spk) begin
               failures++;
               $display("FAIL rand_spk c%0d: got %b expected %b", c, output_spikes, e_spk);
            end
            checks++;
            if (spike_valid !== e_valid) begin
               failures++;
               $display("FAIL rand_valid c%0d: got %b expected %b", c, spike_valid, e_valid);
            end
         end
      end
   endtask

   initial begin
      reset        = 1'b0;
      enable       = 1'b0;
      step         = 1'b0;
      input_spikes = '0;
      clear_cfg();
      model_reset();
      test_reset();
      test_integrate();
      test_delay();
      test_saturation();
      test_refractory();
      test_enable();
      test_reset_pending();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/snn_delay_layer.md
SNN_DELAY_LAYER -- requirements
Module: snn_delay_layer

Interface
REQ-001 SHALL have parameter M, default 24, input spike channels.
REQ-002 SHALL have parameter N, default 8, LIF neurons.
REQ-003 SHALL have parameter DW, default 3, delay field width; depth D = 2^DW, so delays 0..D-1.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port enable, input, 1, global gate; low means all state holds.
REQ-007 SHALL have port step, input, 1, timestep strobe.
REQ-008 SHALL have port input_spikes, input, M, spikes for the current timestep.
REQ-009 SHALL have port weights, input, N*M*8, signed two's-complement; synapse (n,m) at bits [(n*M+m)*8 +: 8].
REQ-010 SHALL have port delay_values, input, N*M*DW, delay of synapse (n,m) at [(n*M+m)*DW +: DW].
REQ-011 SHALL have port synapse_en, input, N*M, per-synapse enable at bit n*M+m.
REQ-012 SHALL have ports threshold, decay and refractory_period, each input, 8, unsigned, shared by all neurons.
REQ-013 SHALL have port membrane_potential_out, output, N*8, neuron n at [n*8 +: 8].
REQ-014 SHALL have port output_spikes, output, N, registered spike pulses.
REQ-015 SHALL have port spike_valid, output, 1, pulse marking a processed timestep.

Function
REQ-016 A timestep SHALL be processed in a cycle where enable=1 and step=1; this is the "tick".
REQ-017 SHALL keep a per-channel history hist[m] of D-1 bits.
- On each tick: hist[m] <= {hist[m][D-3:0], input_spikes[m]}.
- For D=2: hist[m] <= input_spikes[m].
REQ-018 Delayed spike s(n,m) SHALL be:
- input_spikes[m] when delay=0;
- otherwise hist[m][delay-1], sampled before that tick's shift.
- A spike presented at tick t therefore arrives at tick t+delay.
REQ-019 Synaptic sum S_n SHALL be the signed sum of weights(n,m) over all m with synapse_en=1 and s(n,m)=1.
- Sum width 8+clog2(M)+1 bits; no overflow permitted.
REQ-020 SHALL keep per neuron an 8-bit unsigned potential P_n and an 8-bit refractory counter R_n.
REQ-021 On a tick with R_n>0:
- R_n <= R_n-1;
- P_n <= 0;
- no spike from neuron n.
REQ-022 On a tick with R_n=0:
- Compute V = P_n + S_n - decay in signed arithmetic wide enough to be exact.
- Saturate V to the range 0..255.
REQ-023 If saturated V >= threshold, neuron n SHALL spike:
- output_spikes[n] <= 1;
- P_n <= 0;
- R_n <= refractory_period.
- Otherwise P_n <= saturated V and output_spikes[n] <= 0.
REQ-024 threshold=0 SHALL make every non-refractory neuron spike on every tick.
REQ-025 refractory_period=0 SHALL allow the neuron to integrate again on the very next tick.
REQ-026 Registered outputs SHALL become visible one cycle after the tick.
- output_spikes: 1 or 0 per REQ-023.
- spike_valid: 1.
- Both SHALL be 0 in every cycle following a non-tick cycle (one-cycle pulse semantics).
REQ-027 When enable=0, hist, P_n and R_n SHALL hold, and step SHALL be ignored.
REQ-028 membrane_potential_out SHALL continuously reflect the registered P_n.
REQ-029 Changing weights, delays or parameters between ticks SHALL take effect on the next tick, with no pipeline flush needed.

Reset
REQ-030 On a clock edge with reset=1, the following SHALL be 0 on the next cycle, overriding enable and step:
- hist;
- all P_n and R_n;
- output_spikes;
- spike_valid.
REQ-031 Reset asserted mid-refractory or mid-delay SHALL discard all pending delayed spikes; no spike from before reset may arrive after it.

Verification
REQ-032 Weight(0,0)=+10, delay 0, threshold=30, decay=0; input 0 spiking on 3 consecutive ticks -> P_0 reads 10, 20, then 0 with output_spikes[0]=1 and spike_valid=1 one cycle after the third tick.
REQ-033 Delay(1,5)=5, weight=+50, threshold=40; single spike on input 5 at tick 0 -> neuron 1 spikes only after tick 5, nothing before.
REQ-034 Weight=-100, P_0=20, decay=3 -> P_0 saturates to 0; weight=+127 on 3 synapses from P_0=200, threshold=255 -> P_0 saturates to 255 and spikes.
REQ-035 refractory_period=2 after a spike, with a strong input every tick -> no spike on the next 2 ticks, P_0=0 on both, spike on the third.
REQ-036 enable=0 with step pulses and spikes present -> P_n, hist and outputs unchanged; re-enable resumes from the held state.
REQ-037 Reset asserted between a delayed spike's arrival and its due tick -> after reset the spike never arrives and all outputs read 0.
